// File: rtl/bitwise_issue.sv
// bitwise_issue: in-order issue stage for the bitwise unit.
// Instructions {aluop[1:0], Rn[1:0], imm[7:0]} queue in a small FIFO. The
// head entry is loaded onto op/bw_in and launched with a one-cycle s pulse.
// The stage then waits for a rising edge on done, captures bw_out into result
// and retires the entry. A watchdog drops an entry whose done never arrives
// and sets the sticky err flag.
`timescale 1ns/1ps

module bitwise_issue #(
  parameter int DEPTH   = 4,   // FIFO entries, power of two, >= 2
  parameter int AW      = 2,   // log2(DEPTH)
  parameter int TIMEOUT = 16   // cycles allowed in WAIT before a drop, >= 4
) (
  input  logic          clk,
  input  logic          reset_n,
  // upstream instruction stream
  input  logic          instr_valid,
  input  logic [11:0]   instr,
  output logic          instr_ready,
  // bitwise unit handshake
  output logic          s,
  output logic [3:0]    op,
  output logic [7:0]    bw_in,
  input  logic          done,
  input  logic [7:0]    bw_out,
  // results and status
  output logic [7:0]    result,
  output logic          result_valid,
  output logic [AW:0]   count,
  output logic          err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_1  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_1    = AW'(1);
  localparam logic [TW-1:0] TIMER_1  = TW'(1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RETIRE,
    S_DROP
  } state_t;

  state_t          state;
  logic [11:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TW-1:0]   timer;
  logic            done_q;
  logic            done_rise;
  logic            push;
  logic            pop;

  // Acceptance depends only on registered occupancy, so a full FIFO refuses
  // a push even in the cycle an entry retires.
  assign instr_ready = (count < DEPTH_C);
  assign push        = instr_valid & instr_ready;
  assign pop         = (state == S_RETIRE) || (state == S_DROP);
  assign done_rise   = done & ~done_q;

  // Entry storage: written at the tail on every accepted push.
  // NOTE: storage carries no reset; count and the pointers define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= instr;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count as is.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_1;
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_1;
        2'b01:   count <= count - COUNT_1;
        default: count <= count;
      endcase
    end
  end

  // One-cycle delayed done for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done;
    end
  end

  // Issue controller: load head, strobe s, wait for done or time out, retire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      s            <= 1'b0;
      op           <= '0;
      bw_in        <= '0;
      timer        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      // Pulsed outputs default low and are raised only on the entering edge.
      s            <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            op    <= mem[rd_ptr][11:8];
            bw_in <= mem[rd_ptr][7:0];
            s     <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + TIMER_1;
          if (done_rise) begin
            result       <= bw_out;
            result_valid <= 1'b1;
            state        <= S_RETIRE;
          end else if (timer == T_LAST) begin
            state <= S_DROP;
          end
        end
        S_RETIRE: begin
          state <= S_IDLE;
        end
        S_DROP: begin
          err   <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_issue.sv
// Testbench for bitwise_issue. A reference queue of accepted instructions is
// compared against every s pulse, and a queue of responder values against
// every result_valid pulse. A stub bitwise responder answers each launch
// after a random delay, or stays silent / holds off on request.
`timescale 1ns/1ps

module tb_bitwise_issue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [11:0] instr = '0;
  logic        done = 1'b0;
  logic [7:0]  bw_out = '0;
  logic        instr_ready;
  logic        s;
  logic [3:0]  op;
  logic [7:0]  bw_in;
  logic [7:0]  result;
  logic        result_valid;
  logic [2:0]  count;
  logic        err;

  bitwise_issue #(.DEPTH(4), .AW(2), .TIMEOUT(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .s            (s),
    .op           (op),
    .bw_in        (bw_in),
    .done         (done),
    .bw_out       (bw_out),
    .result       (result),
    .result_valid (result_valid),
    .count        (count),
    .err          (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_s = -100;
  int n_rv  = 0;
  int n_s   = 0;

  logic [11:0] exp_instr[$];
  logic [7:0]  exp_result[$];
  bit          stuck = 1'b0;
  bit          hold  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every launch and every result against the scoreboard.
  initial begin : monitor
    logic [11:0] e;
    logic [7:0]  r;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n && s) begin
        n_s++;
        check("s_spacing", 32'((cyc - last_s) >= 4), 32'd1);
        last_s = cyc;
        if (exp_instr.size() == 0) begin
          check("issue_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_instr.pop_front();
          check("issue_op", 32'(op), 32'(e[11:8]));
          check("issue_imm", 32'(bw_in), 32'(e[7:0]));
        end
      end
      if (reset_n && result_valid) begin
        n_rv++;
        if (exp_result.size() == 0) begin
          check("result_unexpected", 32'd1, 32'd0);
        end else begin
          r = exp_result.pop_front();
          check("result_value", 32'(result), 32'(r));
        end
      end
    end
  end

  // Stub bitwise: after a launch, raise done for one cycle during WAIT.
  initial begin : responder
    int d;
    int guard;
    logic [7:0] v;
    forever begin
      @(negedge clk);
      if (reset_n && s && !stuck) begin
        @(negedge clk);
        guard = 0;
        while (hold && guard < 1000) begin
          @(negedge clk);
          guard++;
        end
        d = $urandom_range(0, 3);
        repeat (d) @(negedge clk);
        v = 8'($urandom);
        bw_out = v;
        done = 1'b1;
        exp_result.push_back(v);
        @(negedge clk);
        done = 1'b0;
        bw_out = 8'($urandom);
      end
    end
  end

  // Offer one instruction for one cycle; called at a negedge.
  task automatic push(input logic [11:0] v, output bit acc);
    instr = v;
    instr_valid = 1'b1;
    acc = instr_ready;
    if (acc) exp_instr.push_back(v);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (count != 3'd0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check(name, 32'(count), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_s(input string name);
    int g;
    g = 0;
    while (!s && g < 50) begin
      @(negedge clk);
      g++;
    end
    check(name, 32'(s), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    bit acc;
    int n;
    int rv0;
    int s0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_op", 32'(op), 32'd0);
    check("rst_bw_in", 32'(bw_in), 32'd0);

    // ---- single MOV R1 42, latency N+2 ----
    rv0 = n_rv;
    push(12'h12A, acc);
    check("t1_acc", 32'(acc), 32'd1);
    check("t1_s_n1", 32'(s), 32'd0);
    @(negedge clk);
    check("t1_s_n2", 32'(s), 32'd1);
    check("t1_op", 32'(op), 32'h1);
    check("t1_bw_in", 32'(bw_in), 32'd42);
    @(negedge clk);
    check("t1_s_one_cycle", 32'(s), 32'd0);
    wait_idle("t1_drain");
    check("t1_rv_pulses", 32'(n_rv - rv0), 32'd1);

    // ---- fill to DEPTH with done held off, fifth push refused ----
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(12'($urandom), acc);
      check("t2_acc", 32'(acc), 32'd1);
    end
    check("t2_count_full", 32'(count), 32'd4);
    check("t2_ready_low", 32'(instr_ready), 32'd0);
    push(12'hFFF, acc);
    check("t2_fifth_refused", 32'(acc), 32'd0);
    check("t2_count_still_full", 32'(count), 32'd4);
    hold = 1'b0;
    wait_idle("t2_drain");
    check("t2_instr_q_empty", 32'(exp_instr.size()), 32'd0);
    check("t2_result_q_empty", 32'(exp_result.size()), 32'd0);

    // ---- watchdog drop, next entry still issues ----
    stuck = 1'b1;
    rv0 = n_rv;
    push(12'h3C5, acc);
    push(12'h281, acc);
    wait_s("t3_first_s");
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t3_drop_latency", 32'(n), 32'd18);
    check("t3_count_after_drop", 32'(count), 32'd1);
    check("t3_no_rv_on_drop", 32'(n_rv - rv0), 32'd0);
    stuck = 1'b0;
    wait_idle("t3_drain");
    check("t3_err_sticky", 32'(err), 32'd1);
    check("t3_second_retired", 32'(n_rv - rv0), 32'd1);

    // ---- push in the RETIRE cycle at count=2 ----
    hold = 1'b1;
    push(12'h0A5, acc);
    push(12'h1B6, acc);
    hold = 1'b0;
    n = 0;
    while (!result_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_retire_seen", 32'(result_valid), 32'd1);
    check("t4_count_at_retire", 32'(count), 32'd2);
    push(12'h2C7, acc);
    check("t4_acc", 32'(acc), 32'd1);
    check("t4_count_unchanged", 32'(count), 32'd2);
    wait_idle("t4_drain");
    check("t4_instr_q_empty", 32'(exp_instr.size()), 32'd0);

    // ---- asynchronous reset while s is high ----
    stuck = 1'b1;
    push(12'h3FF, acc);
    push(12'h155, acc);
    wait_s("t5_s_before_reset");
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_s_async", 32'(s), 32'd0);
    check("t5_count_async", 32'(count), 32'd0);
    check("t5_err_async", 32'(err), 32'd0);
    check("t5_result_async", 32'(result), 32'd0);
    check("t5_rv_async", 32'(result_valid), 32'd0);
    @(negedge clk);
    exp_instr.delete();
    exp_result.delete();
    reset_n = 1'b1;
    stuck = 1'b0;
    s0 = n_s;
    repeat (6) @(negedge clk);
    check("t5_no_issue_after", 32'(n_s - s0), 32'd0);
    check("t5_count_after", 32'(count), 32'd0);
    check("t5_ready_after", 32'(instr_ready), 32'd1);

    // ---- randomized traffic ----
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) push(12'($urandom), acc);
      else @(negedge clk);
    end
    wait_idle("rand_drain");
    check("rand_err", 32'(err), 32'd0);
    check("rand_instr_q_empty", 32'(exp_instr.size()), 32'd0);
    check("rand_result_q_empty", 32'(exp_result.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
